shift_signed_divider: RTL and testbench

Sequential shift-subtract (restoring) signed divider. It is the inverse operation of the team's shift-add signed multiplier and is used to recover an operand from a product. It retires one quotient bit per clock and presents quotient, remainder and status flags with a one-cycle `done` pulse. It sits beside the multiplier in the arithmetic datapath and has a start/busy/done handshake, so a controller can issue back-to-back operations.

---
 rtl/shift_signed_divider_pkg.sv | 27 ++
 rtl/shift_signed_divider_if.sv | 39 +++
 rtl/shift_signed_divider_step.sv | 31 +++
 rtl/shift_signed_divider.sv | 170 +++++++++++++++++
 tb/tb_shift_signed_divider.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_signed_divider_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the shift-subtract signed divider.
//   - state encodings (raw localparams plus the enum built on them)
//   - default operand width
//   - helper that sizes the iteration counter for a given operand width
// ----------------------------------------------------------------------------
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_signed_divider_if.sv
// ----------------------------------------------------------------------------
// shift_signed_divider_if
// Groups the start/busy/done handshake, operands and results of the divider.
//   master : issues requests (start, dividend, divisor), observes results
//   slave  : the divider itself
// Ports:
//   start        request, sampled only while the divider is idle
//   dividend     signed numerator
//   divisor      signed denominator
//   busy         operation in progress
//   done         one-cycle completion pulse
//   quotient     signed quotient, held until the next completion
//   remainder    signed remainder, held until the next completion
//   div_by_zero  last completed operation had a zero divisor
//   overflow     last completed operation was MIN / -1
// ----------------------------------------------------------------------------
interface shift_signed_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/shift_signed_divider_step.sv
// ----------------------------------------------------------------------------
// restoring_div_step
// One combinational iteration of an unsigned restoring divider.
// Ports:
//   rem_i           current partial remainder (always < divisor_i)
//   dividend_bit_i  next dividend magnitude bit, shifted into the remainder
//   divisor_i       divisor magnitude
//   rem_o           partial remainder after the trial subtraction
//   quo_bit_o       quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Because rem_i < divisor_i <= 2^(WIDTH-1), the shifted value stays below
  // 2^WIDTH, so the top bit of the (WIDTH+1)-bit difference is a clean borrow.
  assign shifted   = {rem_i, dividend_bit_i};
  assign diff      = shifted - {1'b0, divisor_i};
  assign quo_bit_o = ~diff[WIDTH];
  assign rem_o     = quo_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/shift_signed_divider.sv
// ----------------------------------------------------------------------------
// shift_signed_divider
// Sequential restoring signed divider, one quotient bit per clock.
// Latency from the accepting edge to the done pulse is WIDTH+1 edges.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    shift_signed_divider_if slave (handshake, operands, results, flags)
// ----------------------------------------------------------------------------
module shift_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_signed_divider_if.slave bus
);

  localparam int                CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_pend_q, dz_pend_d;
  logic             ov_pend_q, ov_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  // Magnitudes as unsigned values; negating MIN wraps to 2^(WIDTH-1), which
  // is exactly the magnitude we want.
  assign dividend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign divisor_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  // quo_q doubles as the dividend shift register: its MSB is the next
  // dividend bit, and quotient bits enter at the LSB.
  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (quo_q[WIDTH-1]),
    .divisor_i      (dvs_q),
    .rem_o          (step_rem),
    .quo_bit_o      (step_bit)
  );

  // Next-state and datapath logic for IDLE -> CALC (WIDTH edges) -> FIX.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dividend_d    = dividend_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dz_pend_d     = dz_pend_q;
    ov_pend_d     = ov_pend_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_neg_d    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          r_neg_d    = bus.dividend[WIDTH-1];
          quo_d      = dividend_mag;
          dvs_d      = divisor_mag;
          rem_d      = '0;
          cnt_d      = '0;
          dividend_d = bus.dividend;
          dz_pend_d  = (bus.divisor == '0);
          ov_pend_d  = (bus.dividend == MIN_VAL) && (bus.divisor == ALL_ONES);
          state_d    = CALC;
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // A zero divisor still runs the full iteration count; its datapath
        // result is simply discarded here.
        if (dz_pend_q) begin
          quotient_d  = ALL_ONES;
          remainder_d = dividend_q;
        end else begin
          quotient_d  = q_neg_q ? -quo_q : quo_q;
          remainder_d = r_neg_q ? -rem_q : rem_q;
        end
        div_by_zero_d = dz_pend_q;
        overflow_d    = ov_pend_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dividend_q    <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dz_pend_q     <= 1'b0;
      ov_pend_q     <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      dividend_q    <= dividend_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dz_pend_q     <= dz_pend_d;
      ov_pend_q     <= ov_pend_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_shift_signed_divider.sv
// ----------------------------------------------------------------------------
// tb_shift_signed_divider
// Scoreboard bench for shift_signed_divider (WIDTH=32). Stimulus pushes the
// expected result of every accepted request; a monitor on the falling edge
// pops and compares whenever done is high.
// ----------------------------------------------------------------------------
module tb_shift_signed_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;
  localparam logic signed [31:0] MIN_V = 32'sh8000_0000;
  localparam logic signed [31:0] MAX_V = 32'sh7fff_ffff;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  shift_signed_divider_if #(.WIDTH(WIDTH)) dif ();

  shift_signed_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  typedef struct {
    string              name;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] q;
    logic signed [31:0] r;
    logic               dz;
    logic               ov;
    int                 accept;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int busy_run     = 0;

  // Edge counter: after the accepting edge it holds that edge's number.
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Reference behaviour: truncating division plus the two special cases.
  function automatic void model(input logic signed [31:0] a,
                                input logic signed [31:0] b,
                                output logic signed [31:0] q,
                                output logic signed [31:0] r,
                                output logic dz, output logic ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = -32'sd1;
      r  = a;
      dz = 1'b1;
    end else if (a == MIN_V && b == -32'sd1) begin
      q  = MIN_V;
      r  = 32'sd0;
      ov = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: compares results, latency and busy duration on each done.
  always @(negedge clk) begin
    if (!reset) begin
      busy_run = 0;
    end else if (dif.done) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, " quotient"}, dif.quotient, mon_e.q);
        checkOutput({mon_e.name, " remainder"}, dif.remainder, mon_e.r);
        checkOutput({mon_e.name, " div_by_zero"}, 32'(dif.div_by_zero), 32'(mon_e.dz));
        checkOutput({mon_e.name, " overflow"}, 32'(dif.overflow), 32'(mon_e.ov));
        checkOutput({mon_e.name, " latency"}, 32'(cyc - mon_e.accept), 32'(LAT));
        checkOutput({mon_e.name, " busy_cycles"}, 32'(busy_run), 32'(LAT));
        if (!mon_e.dz) begin
          checkOutput({mon_e.name, " identity"},
                      32'(dif.quotient * mon_e.b + dif.remainder), mon_e.a);
        end
      end
      busy_run = 0;
    end else if (dif.busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Drive one request for a single cycle and record what it must produce.
  task automatic issue(input string name, input logic signed [31:0] a,
                       input logic signed [31:0] b, input logic signed [31:0] q,
                       input logic signed [31:0] r, input logic dz,
                       input logic ov);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    sb.push_back('{name, a, b, q, r, dz, ov, cyc + 1});
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  // Wait (bounded) until the monitor has consumed every pending result.
  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input string name, input logic signed [31:0] a,
                               input logic signed [31:0] b,
                               input logic signed [31:0] q,
                               input logic signed [31:0] r,
                               input logic dz, input logic ov);
    @(negedge clk);
    issue(name, a, b, q, r, dz, ov);
    waitDrain();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy"}, 32'(dif.busy), 32'd0);
    checkOutput({tag, " done"}, 32'(dif.done), 32'd0);
    checkOutput({tag, " quotient"}, dif.quotient, 32'd0);
    checkOutput({tag, " remainder"}, dif.remainder, 32'd0);
    checkOutput({tag, " div_by_zero"}, 32'(dif.div_by_zero), 32'd0);
    checkOutput({tag, " overflow"}, 32'(dif.overflow), 32'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic signed [31:0] corners [6];
    logic signed [31:0] ra, rb, rq, rr;
    logic               rdz, rov;
    int                 n;

    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    reset        = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset_state");
    reset = 1'b1;

    // Basic sign combinations.
    applyStimulus("7/2",   32'sd7,  32'sd2,  32'sd3,  32'sd1,  1'b0, 1'b0);
    applyStimulus("-7/2",  -32'sd7, 32'sd2,  -32'sd3, -32'sd1, 1'b0, 1'b0);
    applyStimulus("7/-2",  32'sd7,  -32'sd2, -32'sd3, 32'sd1,  1'b0, 1'b0);

    // Overflow case, then a normal op that must clear the flag.
    applyStimulus("min/-1", MIN_V, -32'sd1, MIN_V, 32'sd0, 1'b0, 1'b1);
    applyStimulus("max/min", MAX_V, MIN_V, 32'sd0, MAX_V, 1'b0, 1'b0);

    // Divide by zero, then a normal op that must clear the flag.
    applyStimulus("5/0",   32'sd5,  32'sd0,  -32'sd1, 32'sd5,  1'b1, 1'b0);
    applyStimulus("-9/3",  -32'sd9, 32'sd3,  -32'sd3, 32'sd0,  1'b0, 1'b0);

    // start mid-CALC is ignored; start in the done cycle is accepted.
    @(negedge clk);
    issue("100/7", 32'sd100, 32'sd7, 32'sd14, 32'sd2, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 32'sd1;
    dif.divisor  = 32'sd1;
    @(negedge clk);
    dif.start = 1'b0;
    n = 0;
    while (!dif.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dif.done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_wait_timeout: got done=0, expected done=1");
    end else begin
      issue("50/5_in_done", 32'sd50, 32'sd5, 32'sd10, 32'sd0, 1'b0, 1'b0);
    end
    waitDrain();
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-operation aborts with no done.
    dif.start    = 1'b1;
    dif.dividend = 32'sd1000;
    dif.divisor  = 32'sd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetOutputs("abort");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus("1000/3", 32'sd1000, 32'sd3, 32'sd333, 32'sd1, 1'b0, 1'b0);

    // Corner operand cross product.
    corners = '{32'sd0, 32'sd1, -32'sd1, 32'sd2, MIN_V, MAX_V};
    foreach (corners[i]) begin
      foreach (corners[j]) begin
        model(corners[i], corners[j], rq, rr, rdz, rov);
        applyStimulus("corner", corners[i], corners[j], rq, rr, rdz, rov);
      end
    end

    // Random pairs; every fourth divisor is small to exercise zero and
    // large quotients.
    for (int k = 0; k < 500; k++) begin
      ra = $signed($urandom);
      if (k % 4 == 0) rb = $signed(32'($urandom_range(0, 16))) - 32'sd8;
      else            rb = $signed($urandom);
      model(ra, rb, rq, rr, rdz, rov);
      applyStimulus("random", ra, rb, rq, rr, rdz, rov);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
